// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the frame_tx serial framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Optional feature macro: FRAME_TX_STUFF_EN (zero insertion after STUFF_RUN ones).
package frame_tx_pkg;

  // Framer control states.
  typedef enum logic [1:0] {
    IDLE,
    BEG_FLAG,
    DATA,
    END_FLAG
  } state_e;

  // Delimiter sent before and after every payload, LSB first.
  localparam logic [7:0] FLAG = 8'h7E;

  // Line level between frames.
  localparam logic IDLE_BIT = 1'b0;

  // Number of consecutive payload ones that forces an inserted zero.
  localparam int unsigned STUFF_RUN = 5;

endpackage

// File: rtl/frame_tx_if.sv
// Byte-in / bit-out bundle for frame_tx.
// Latency: n/a (wires only).
// Backpressure: source holds txValid/txData/txLast until txReady is seen high.
//
// Signals: txData[7:0], txValid, txLast (source -> framer); txReady, dataOut,
// busy, frameDone, underrun (framer -> source/line).
// master = byte source, slave = framer.
interface frame_tx_if;
  import frame_tx_pkg::*;

  logic [7:0] txData;
  logic       txValid;
  logic       txLast;
  logic       txReady;
  logic       dataOut;
  logic       busy;
  logic       frameDone;
  logic       underrun;

  modport master (
    output txData, txValid, txLast,
    input  txReady, dataOut, busy, frameDone, underrun
  );

  modport slave (
    input  txData, txValid, txLast,
    output txReady, dataOut, busy, frameDone, underrun
  );

endinterface

// File: rtl/frame_tx_stuffer.sv
// Payload ones-run counter that requests a stuffed zero after STUFF_RUN ones.
// Latency: stuff_req rises the cycle after the bit that completes the run.
// Backpressure: none; the framer decides when bits are counted or cleared.
//
// Ports: clk, reset (sync, active-high); clr clears the run; bit_vld/bit_val
// present one counted payload bit; stuff_req asks for a zero on the next load.
// Only present when FRAME_TX_STUFF_EN is defined, so default builds carry none
// of this logic.
`ifdef FRAME_TX_STUFF_EN
module frame_tx_stuffer
  import frame_tx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_vld,
  input  logic bit_val,
  output logic stuff_req
);

  logic [2:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (clr) begin
      ones_d = '0;
    end else if (bit_vld) begin
      ones_d = bit_val ? ones_q + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  // The run never exceeds STUFF_RUN: the requested zero clears it.
  assign stuff_req = (ones_q == 3'(STUFF_RUN));

endmodule
`endif

// File: rtl/frame_tx.sv
// Serialises payload bytes into FLAG-delimited frames, LSB first, one bit per clk.
// Latency: first FLAG bit on dataOut the cycle after the first byte is accepted.
// Backpressure: txReady only in IDLE and while bit 7 of a non-last byte is loaded.
//
// Ports: clk, reset (sync, active-high); tx (frame_tx_if.slave) carries
// txData/txValid/txLast/txReady in and dataOut/busy/frameDone/underrun out.
// Build option: FRAME_TX_STUFF_EN enables zero insertion after five payload ones.
module frame_tx
  import frame_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  frame_tx_if.slave   tx
);

  state_e     state_q, state_d;
  // Index of the next bit to load into dataOut within the current segment;
  // value 8 in END_FLAG marks the cycle showing the last FLAG bit.
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       last_q, last_d;
  logic       pend_q, pend_d;     // frame is being closed by an underrun
  logic       dout_q, dout_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       urun_q, urun_d;

  logic       ready;
  logic       accept;
  logic       stuff_req;

`ifdef FRAME_TX_STUFF_EN
  logic       ones_clr;
  logic       ones_vld;

  frame_tx_stuffer u_stuffer (
    .clk       (clk),
    .reset     (reset),
    .clr       (ones_clr),
    .bit_vld   (ones_vld),
    .bit_val   (shift_q[cnt_q[2:0]]),
    .stuff_req (stuff_req)
  );
`else
  assign stuff_req = 1'b0;
`endif

  // A pending stuff bit holds off the bit-7 load, and txReady with it.
  assign ready  = (state_q == IDLE) ||
                  ((state_q == DATA) && (cnt_q == 4'd7) && !stuff_req && !last_q);
  assign accept = tx.txValid && ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    last_d  = last_q;
    pend_d  = pend_q;
    dout_d  = IDLE_BIT;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    urun_d  = 1'b0;
`ifdef FRAME_TX_STUFF_EN
    ones_clr = 1'b0;
    ones_vld = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          shift_d = tx.txData;
          last_d  = tx.txLast;
          pend_d  = 1'b0;
          dout_d  = FLAG[0];
          busy_d  = 1'b1;
          cnt_d   = 4'd1;
          state_d = BEG_FLAG;
        end
      end

      BEG_FLAG: begin
        dout_d = FLAG[cnt_q[2:0]];
        if (cnt_q == 4'd7) begin
          cnt_d   = '0;
          state_d = DATA;
`ifdef FRAME_TX_STUFF_EN
          ones_clr = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DATA: begin
        if (stuff_req) begin
          // Inserted zero: the bit index does not advance.
          dout_d = 1'b0;
`ifdef FRAME_TX_STUFF_EN
          ones_clr = 1'b1;
`endif
        end else begin
          dout_d = shift_q[cnt_q[2:0]];
`ifdef FRAME_TX_STUFF_EN
          ones_vld = 1'b1;
`endif
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (accept) begin
              // Next byte follows bit 7 with no gap.
              shift_d = tx.txData;
              last_d  = tx.txLast;
            end else begin
              // Either txLast was set, or the source ran dry (underrun).
              state_d = END_FLAG;
              pend_d  = !last_q;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      END_FLAG: begin
        if (cnt_q == 4'd8) begin
          // Guaranteed idle bit between frames.
          dout_d  = IDLE_BIT;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (stuff_req && (cnt_q == 4'd0)) begin
          // Stuff owed after bit 7 of the final byte goes out before the FLAG.
          dout_d = 1'b0;
`ifdef FRAME_TX_STUFF_EN
          ones_clr = 1'b1;
`endif
        end else begin
          dout_d = FLAG[cnt_q[2:0]];
          urun_d = pend_q && (cnt_q == 4'd0);
          done_d = (cnt_q == 4'd7);
          cnt_d  = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      dout_q  <= IDLE_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
    end
  end

  assign tx.txReady   = ready;
  assign tx.dataOut   = dout_q;
  assign tx.busy      = busy_q;
  assign tx.frameDone = done_q;
  assign tx.underrun  = urun_q;

endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx: the driver builds each frame's expected bit
// stream from the framing rules and queues it with absolute cycle stamps; a
// monitor compares every cycle against the queue, or against idle when empty.
module tb_frame_tx;
  import frame_tx_pkg::*;

`ifdef FRAME_TX_STUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  typedef struct packed {
    int   cyc;
    logic d;
    logic bsy;
    logic done;
    logic ur;
  } exp_t;

  logic clk;
  logic reset;
  frame_tx_if tif ();

  frame_tx dut (
    .clk   (clk),
    .reset (reset),
    .tx    (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  int   prev_idle = 0;

  exp_t sb[$];
  exp_t frm[$];
  int   p7[$];
  logic [7:0] fb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!tif.txValid) begin
      tif.txData = 8'($urandom);
      tif.txLast = 1'($urandom);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic bsy, input logic done, input logic ur);
    exp_t e;
    e.cyc  = 0;
    e.d    = d;
    e.bsy  = bsy;
    e.done = done;
    e.ur   = ur;
    return e;
  endfunction

  // Expected line bits for fb[]: FLAG, payload LSB first with a zero after
  // every run of five payload ones, FLAG, one idle bit.
  task automatic model(input bit urun);
    logic [7:0] fl;
    logic [7:0] cur;
    int ones;
    fl = 8'h7E;
    ones = 0;
    frm.delete();
    p7.delete();
    for (int k = 0; k < 8; k++) frm.push_back(mk(fl[k], 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < fb.size(); i++) begin
      cur = fb[i];
      for (int k = 0; k < 8; k++) begin
        if (STUFF && ones == 5) begin
          frm.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
          ones = 0;
        end
        frm.push_back(mk(cur[k], 1'b1, 1'b0, 1'b0));
        if (k == 7) p7.push_back(frm.size() - 1);
        ones = cur[k] ? ones + 1 : 0;
      end
    end
    if (STUFF && ones == 5) frm.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 8; k++)
      frm.push_back(mk(fl[k], 1'b1, k == 7, urun && k == 0));
    frm.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Drives fb[] as one frame. urun: last byte sent without txLast, then valid
  // drops. do_rst: reset is applied during the 12th line cycle of the frame.
  task automatic run_frame(input bit urun, input bit do_rst);
    int a, acc, want, n;
    bit ok;
    exp_t e;
    n = fb.size();
    a = 0;
    model(urun);
    repeat ($urandom_range(0, 2)) tick();
    for (int i = 0; i < n; i++) begin
      tif.txValid = 1'b1;
      tif.txData  = fb[i];
      tif.txLast  = !urun && (i == n - 1);
      if (i == 0) want = (cyc + 1 > prev_idle + 1) ? cyc + 1 : prev_idle + 1;
      else        want = a + p7[i-1];
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (tif.txReady === 1'b1) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout byte=%0d got=no_txReady want=txReady_within_300", i);
        tif.txValid = 1'b0;
        return;
      end
      acc = cyc + 1;
      chk("accept_cycle", acc, want);
      if (i == 0) begin
        a = acc;
        for (int j = 0; j < frm.size(); j++) begin
          if (!do_rst || j <= 11) begin
            e = frm[j];
            e.cyc = a + j;
            sb.push_back(e);
          end
        end
      end
      @(posedge clk);
      #1;
      if (do_rst) break;
    end

    if (do_rst) begin
      tif.txValid = 1'b1;
      tif.txData  = fb[1];
      tif.txLast  = 1'b1;
      while (cyc < a + 11) tick();
      reset = 1'b1;
      tif.txValid = 1'b0;
      tick();
      reset = 1'b0;
      chk("post_reset", {27'd0, tif.dataOut, tif.busy, tif.txReady, tif.frameDone, tif.underrun},
          32'b00100);
      prev_idle = a + 12;
      return;
    end

    tif.txValid = 1'b0;
    prev_idle = a + frm.size() - 1;
    // Keep valid low past the bit-7 ready window so the underrun is taken.
    if (urun) while (cyc < prev_idle) tick();
  endtask

  // Monitor: stamped entries must appear on exactly their cycle; any other
  // cycle must look idle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL stream_missed got=unchecked want_cyc=%0d", e.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("stream", {28'd0, tif.dataOut, tif.busy, tif.frameDone, tif.underrun},
            {28'd0, e.d, e.bsy, e.done, e.ur});
      end else begin
        chk("idle", {27'd0, tif.dataOut, tif.busy, tif.txReady, tif.frameDone, tif.underrun},
            32'b00100);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tif.txValid = 1'b0;
    tif.txData  = 8'h00;
    tif.txLast  = 1'b0;
    tick();
    mon_en = 1'b1;
    repeat (3) begin
      tick();
      chk("reset_state", {27'd0, tif.dataOut, tif.busy, tif.txReady, tif.frameDone, tif.underrun},
          32'b00100);
    end
    reset = 1'b0;
    prev_idle = cyc;

    fb = '{8'h00};        run_frame(1'b0, 1'b0);
    fb = '{8'hFF};        run_frame(1'b0, 1'b0);
    fb = '{8'h1F, 8'hF8}; run_frame(1'b0, 1'b0);
    fb = '{8'hA5};        run_frame(1'b1, 1'b0);
    fb = '{8'hC3, 8'h3C}; run_frame(1'b0, 1'b1);
    fb = '{8'h3E, 8'h7E}; run_frame(1'b0, 1'b0);
    fb = '{8'hF0, 8'h0F}; run_frame(1'b1, 1'b0);

    for (int f = 0; f < 40; f++) begin
      fb.delete();
      for (int i = 0; i < $urandom_range(1, 4); i++)
        fb.push_back(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
      run_frame($urandom_range(0, 3) == 0, 1'b0);
    end

    for (int t = 0; t < 400 && sb.size() > 0; t++) tick();
    chk("drain", sb.size(), 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
